// File: rtl/btn_pkg.sv
// Shared constants and helpers for the push-button conditioner.
// Event code layout is {kind, idx[3:0]}.
package btn_pkg;
    localparam int   EVT_W        = 5;
    localparam int   IDX_W        = 4;
    localparam logic KIND_PRESS   = 1'b0;
    localparam logic KIND_RELEASE = 1'b1;
    localparam int   SEL_W        = 32;

    // Map a raw pin to "1 = pressed".
    function automatic logic norm_pol(input logic raw, input logic active_low);
        return active_low ? ~raw : raw;
    endfunction

    function automatic logic [4:0] lowest_set(input logic [SEL_W-1:0] v);
        logic [4:0] idx;
        idx = '0;
        for (int i = SEL_W - 1; i >= 0; i--) begin
            if (v[i]) idx = 5'(i);
        end
        return idx;
    endfunction
endpackage

// File: rtl/btn_debounce.sv
// One button: 2-FF synchroniser, counter debounce, registered edge pulses.
// Raw edge to level is 2 + DEBOUNCE_CYC cycles; pulses follow one cycle later.
module btn_debounce
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYC   = 500000,
    parameter bit BTN_ACTIVE_LOW = 1'b1
) (
    input  logic clock,
    input  logic resetn,
    input  logic raw,
    output logic level,
    output logic rise
`ifdef BTN_EVT_RELEASE_EN
    ,
    output logic fall
`endif
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYC - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             level_dly_q, level_dly_d;
    logic             rise_q, rise_d;
`ifdef BTN_EVT_RELEASE_EN
    logic             fall_q, fall_d;
`endif

    always_comb begin
        sync1_d = norm_pol(raw, BTN_ACTIVE_LOW);
        sync2_d = sync1_q;
        cnt_d   = '0;
        level_d = level_q;
        // Any return to the current level leaves cnt_d at zero, restarting the count.
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        level_dly_d = level_q;
        rise_d      = level_q & ~level_dly_q;
`ifdef BTN_EVT_RELEASE_EN
        fall_d      = ~level_q & level_dly_q;
`endif
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            cnt_q       <= '0;
            level_q     <= 1'b0;
            level_dly_q <= 1'b0;
            rise_q      <= 1'b0;
`ifdef BTN_EVT_RELEASE_EN
            fall_q      <= 1'b0;
`endif
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            level_dly_q <= level_dly_d;
            rise_q      <= rise_d;
`ifdef BTN_EVT_RELEASE_EN
            fall_q      <= fall_d;
`endif
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
`ifdef BTN_EVT_RELEASE_EN
    assign fall  = fall_q;
`endif
endmodule

// File: rtl/button_conditioner.sv
// Debounced button levels, press pulses and a FWFT event queue (press first, lowest index first).
// Define BTN_EVT_RELEASE_EN to also queue release events (kind=1).
module button_conditioner
    import btn_pkg::*;
#(
    parameter int NUM_BTN        = 9,
    parameter int DEBOUNCE_CYC   = 500000,
    parameter int FIFO_DEPTH     = 4,
    parameter bit BTN_ACTIVE_LOW = 1'b1
) (
    input  logic               clock,
    input  logic               resetn,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_press,
    output logic               evt_valid,
    output logic [EVT_W-1:0]   evt_code,
    input  logic               evt_ready,
    output logic               evt_overflow,
    input  logic               evt_clear
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

    logic [NUM_BTN-1:0] rise;
    logic [NUM_BTN-1:0] pend_q, pend_d, pend_clr, drop;
`ifdef BTN_EVT_RELEASE_EN
    logic [NUM_BTN-1:0] fall;
    logic [NUM_BTN-1:0] pend_rel_q, pend_rel_d, rel_clr, drop_rel;
`endif

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYC   (DEBOUNCE_CYC),
            .BTN_ACTIVE_LOW (BTN_ACTIVE_LOW)
        ) u_deb (
            .clock  (clock),
            .resetn (resetn),
            .raw    (btn_raw[i]),
            .level  (btn_level[i]),
            .rise   (rise[i])
`ifdef BTN_EVT_RELEASE_EN
            ,
            .fall   (fall[i])
`endif
        );
    end

    assign btn_press = rise;

    logic [EVT_W-1:0] mem_q [FIFO_DEPTH];
    logic [EVT_W-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             ovf_q, ovf_d;

    logic [SEL_W-1:0] sel_vec;
    logic [4:0]       sel_bit;
    logic [EVT_W-1:0] push_code;
    logic             full, empty, push, pop;

    always_comb begin
        sel_vec = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
`ifdef BTN_EVT_RELEASE_EN
            // Interleave so press[i] outranks release[i], which outranks press[i+1].
            sel_vec[2*i]   = pend_q[i];
            sel_vec[2*i+1] = pend_rel_q[i];
`else
            sel_vec[i]     = pend_q[i];
`endif
        end
        sel_bit = lowest_set(sel_vec);
`ifdef BTN_EVT_RELEASE_EN
        push_code = {sel_bit[0], sel_bit[4:1]};
`else
        // Index is below 16, so the kind bit comes out as KIND_PRESS.
        push_code = sel_bit;
`endif
        full  = (occ_q == OCC_FULL);
        empty = (occ_q == '0);
        pop   = evt_ready && !empty;
        push  = (|sel_vec) && (!full || pop);

        pend_clr = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            pend_clr[i] = push && (push_code == {KIND_PRESS, IDX_W'(i)});
        end
        drop   = rise & pend_q & ~pend_clr;
        pend_d = (pend_q & ~pend_clr) | rise;
`ifdef BTN_EVT_RELEASE_EN
        rel_clr = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            rel_clr[i] = push && (push_code == {KIND_RELEASE, IDX_W'(i)});
        end
        drop_rel   = fall & pend_rel_q & ~rel_clr;
        pend_rel_d = (pend_rel_q & ~rel_clr) | fall;
        ovf_d = ((|drop) || (|drop_rel)) ? 1'b1 : (evt_clear ? 1'b0 : ovf_q);
`else
        ovf_d = (|drop) ? 1'b1 : (evt_clear ? 1'b0 : ovf_q);
`endif

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_code;
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
        end
        occ_d = occ_q;
        if (push && !pop) occ_d = occ_q + 1'b1;
        else if (!push && pop) occ_d = occ_q - 1'b1;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pend_q   <= '0;
`ifdef BTN_EVT_RELEASE_EN
            pend_rel_q <= '0;
`endif
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            pend_q   <= pend_d;
`ifdef BTN_EVT_RELEASE_EN
            pend_rel_q <= pend_rel_d;
`endif
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            ovf_q    <= ovf_d;
        end
    end

    assign evt_valid    = !empty;
    assign evt_code     = empty ? '0 : mem_q[rd_ptr_q];
    assign evt_overflow = ovf_q;
endmodule
